// File: rtl/game_session_ctrl_pkg.sv
// Shared definitions for the game session sequencer: session state encodings,
// the "no best score yet" marker and default timing/limit constants.
package game_pkg;

    // Session states, kept as plain constants for compatibility with legacy decoders
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PLAY = 3'd1;
    localparam logic [2:0] ST_EVAL = 3'd2;
    localparam logic [2:0] ST_WON  = 3'd3;
    localparam logic [2:0] ST_LOST = 3'd4;

    localparam logic [3:0] BEST_NONE = 4'hF;

    localparam int DEBOUNCE_CYC_DEF = 1000000;
    localparam int MAX_ATTEMPTS_DEF = 10;
    localparam int EVAL_LAT_DEF     = 2;

endpackage

// File: rtl/game_session_ctrl_btn_debounce.sv
// Button filter: the accepted level follows the raw level only after the two
// have differed for DEBOUNCE_CYC consecutive cycles; press marks a 0->1 acceptance.
module btn_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic resetb,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int             CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    // Next-state: count consecutive disagreeing cycles, flip level on the last one
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (raw == level_q) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = CNT_ZERO;
            level_d = raw;
            press_d = raw;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Filter state registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/game_session_ctrl.sv
// Session sequencer between the push buttons and the code-break engine: issues
// start/confirm pulses, tracks guesses and round outcome, and keeps statistics.
module game_session_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int EVAL_LAT     = EVAL_LAT_DEF,
    parameter int MAX_ATTEMPTS = MAX_ATTEMPTS_DEF,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             btn_start,
    input  logic             btn_confirm,
    input  logic             code_break,
    input  logic             timer_expires,
    output logic             start_pulse,
    output logic             confirm_pulse,
    output logic             round_active,
    output logic             round_won,
    output logic             round_lost,
    output logic [3:0]       attempts,
    output logic [CNT_W-1:0] wins,
    output logic [CNT_W-1:0] losses,
    output logic [3:0]       best_attempts
);

    localparam int               EW        = (EVAL_LAT > 0) ? $clog2(EVAL_LAT + 1) : 1;
    localparam logic [EW-1:0]    EVAL_LOAD = EW'(EVAL_LAT);
    localparam logic [EW-1:0]    EVAL_ONE  = EW'(1);
    localparam logic [EW-1:0]    EVAL_ZERO = {EW{1'b0}};
    localparam logic [3:0]       ATT_MAX   = 4'(MAX_ATTEMPTS);
    localparam logic [CNT_W-1:0] CNT_FULL  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    logic             start_level_s, start_press_s, confirm_level_s, confirm_press_s;
    logic             start_ev_s, confirm_ev_s;
    logic [2:0]       state_q, state_d;
    logic [3:0]       attempts_q, attempts_d, best_q, best_d;
    logic [EW-1:0]    eval_q, eval_d;
    logic [CNT_W-1:0] wins_q, wins_d, losses_q, losses_d;
    logic             start_p_q, start_p_d, confirm_p_q, confirm_p_d;
    logic             active_q, won_q, lost_q;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_start (
        .clk(clk), .resetb(resetb), .raw(btn_start), .level(start_level_s), .press(start_press_s)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_confirm (
        .clk(clk), .resetb(resetb), .raw(btn_confirm), .level(confirm_level_s), .press(confirm_press_s)
    );

    // A press always coincides with its accepted level rising; both views must agree
    assign start_ev_s   = start_press_s & start_level_s;
    assign confirm_ev_s = confirm_press_s & confirm_level_s;

    // Session FSM, attempt/eval counters and statistics next-state
    always_comb begin
        state_d     = state_q;
        attempts_d  = attempts_q;
        eval_d      = eval_q;
        wins_d      = wins_q;
        losses_d    = losses_q;
        best_d      = best_q;
        start_p_d   = 1'b0;
        confirm_p_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ev_s) begin
                    start_p_d  = 1'b1;
                    attempts_d = 4'd0;
                    state_d    = ST_PLAY;
                end else begin
                    confirm_p_d = confirm_ev_s;
                end
            end
            ST_PLAY: begin
                if (timer_expires) begin
                    state_d = ST_LOST;
                end else if (confirm_ev_s) begin
                    confirm_p_d = 1'b1;
                    attempts_d  = (attempts_q < ATT_MAX) ? attempts_q + 4'd1 : attempts_q;
                    eval_d      = EVAL_LOAD;
                    state_d     = ST_EVAL;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_EVAL: begin
                if (eval_q != EVAL_ZERO) begin
                    eval_d  = eval_q - EVAL_ONE;
                    state_d = timer_expires ? ST_LOST : ST_EVAL;
                end else if (code_break) begin
                    state_d = ST_WON;
                end else if (attempts_q >= ATT_MAX) begin
                    state_d = ST_LOST;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_WON, ST_LOST: begin
                if (start_ev_s) begin
                    start_p_d  = 1'b1;
                    attempts_d = 4'd0;
                    state_d    = ST_PLAY;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Statistics update once, on the cycle the outcome state is entered
        if ((state_d == ST_WON) && (state_q != ST_WON)) begin
            wins_d = (wins_q != CNT_FULL) ? wins_q + CNT_ONE : wins_q;
            best_d = (attempts_q < best_q) ? attempts_q : best_q;
        end else begin
            best_d = best_q;
        end
        if ((state_d == ST_LOST) && (state_q != ST_LOST)) begin
            losses_d = (losses_q != CNT_FULL) ? losses_q + CNT_ONE : losses_q;
        end else begin
            losses_d = losses_q;
        end
    end

    // Session state, statistics and registered status/pulse outputs
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            attempts_q  <= 4'd0;
            eval_q      <= EVAL_ZERO;
            wins_q      <= CNT_ZERO;
            losses_q    <= CNT_ZERO;
            best_q      <= BEST_NONE;
            start_p_q   <= 1'b0;
            confirm_p_q <= 1'b0;
            active_q    <= 1'b0;
            won_q       <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            attempts_q  <= attempts_d;
            eval_q      <= eval_d;
            wins_q      <= wins_d;
            losses_q    <= losses_d;
            best_q      <= best_d;
            start_p_q   <= start_p_d;
            confirm_p_q <= confirm_p_d;
            active_q    <= (state_d == ST_PLAY) || (state_d == ST_EVAL);
            won_q       <= (state_d == ST_WON);
            lost_q      <= (state_d == ST_LOST);
        end
    end

    assign start_pulse   = start_p_q;
    assign confirm_pulse = confirm_p_q;
    assign round_active  = active_q;
    assign round_won     = won_q;
    assign round_lost    = lost_q;
    assign attempts      = attempts_q;
    assign wins          = wins_q;
    assign losses        = losses_q;
    assign best_attempts = best_q;

endmodule
